// File: rtl/list_writer_pkg.sv
// Shared constants for the linked-list writer.
// Node layout, null pointer and FSM encoding.
package list_writer_pkg;

  localparam int NULL_PTR = 0;
  localparam int VAL_OFS  = 0;
  localparam int NXT_OFS  = 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR_VAL = 2'd1;
  localparam logic [1:0] S_WR_NXT = 2'd2;
  localparam logic [1:0] S_LINK   = 2'd3;

  localparam int WP_DATA_W = 32;
  localparam int WP_ADDR_W = 8;

endpackage

// File: rtl/list_node_alloc.sv
// Node allocator: linked-node counter,
// next free node address and full flag.
module list_node_alloc
  import list_writer_pkg::*;
#(
  parameter int ADDR_W    = WP_ADDR_W,
  parameter int BASE_ADDR = 2,
  parameter int MAX_NODES = 64,
  parameter int CNT_W     = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              full_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // next count: clear wins, increments stop at capacity
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && !full_o)
      count_d = count_q + CNT_W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(MAX_NODES));
  assign next_addr_o = ADDR_W'(BASE_ADDR)
                     + (ADDR_W'(count_q) << 1);

endmodule

// File: rtl/list_writer.sv
// Appends stream values to a linked list in RAM.
// Value and null next land before the link write.
module list_writer
  import list_writer_pkg::*;
#(
  parameter int DATA_W    = WP_DATA_W,
  parameter int ADDR_W    = WP_ADDR_W,
  parameter int BASE_ADDR = 2,
  parameter int MAX_NODES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  input  logic                             clear,
  output logic                             we,
  output logic [ADDR_W-1:0]                waddr,
  output logic [DATA_W-1:0]                wdata,
  output logic [ADDR_W-1:0]                head_addr,
  output logic [$clog2(MAX_NODES+1)-1:0]   node_count,
  output logic                             list_full,
  output logic                             busy
);

  localparam int CNT_W = $clog2(MAX_NODES + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] new_q, new_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic              pend_q, pend_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              inc, clr, idle;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  count;
  logic              full;

  list_node_alloc #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .MAX_NODES (MAX_NODES),
    .CNT_W     (CNT_W)
  ) u_alloc (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (inc),
    .clr_i       (clr),
    .count_o     (count),
    .next_addr_o (next_addr),
    .full_o      (full)
  );

  assign idle     = (state_q == S_IDLE);
  assign in_ready = idle && !full && !pend_q && !clear;

  // next state plus the write the next state will present
  always_comb begin
    state_d = state_q;
    new_d   = new_q;
    tail_d  = tail_q;
    head_d  = head_q;
    pend_d  = pend_q;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    inc     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear || pend_q) begin
          clr    = 1'b1;
          head_d = ADDR_W'(NULL_PTR);
          tail_d = ADDR_W'(NULL_PTR);
          pend_d = 1'b0;
        end else if (in_valid && in_ready) begin
          new_d   = next_addr;
          state_d = S_WR_VAL;
          we_d    = 1'b1;
          waddr_d = next_addr + ADDR_W'(VAL_OFS);
          wdata_d = in_data;
        end
      end
      S_WR_VAL: begin
        state_d = S_WR_NXT;
        we_d    = 1'b1;
        waddr_d = new_q + ADDR_W'(NXT_OFS);
        wdata_d = DATA_W'(NULL_PTR);
      end
      S_WR_NXT: begin
        if (count == '0) begin
          head_d  = new_q;
          tail_d  = new_q;
          inc     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_LINK;
          we_d    = 1'b1;
          waddr_d = tail_q + ADDR_W'(NXT_OFS);
          wdata_d = DATA_W'(new_q);
        end
      end
      S_LINK: begin
        tail_d  = new_q;
        inc     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!idle && clear)
      pend_d = 1'b1;
  end

  // state and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      new_q   <= '0;
      tail_q  <= '0;
      head_q  <= '0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      new_q   <= new_d;
      tail_q  <= tail_d;
      head_q  <= head_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign head_addr  = head_q;
  assign node_count = count;
  assign list_full  = full;
  assign busy       = !idle;

endmodule

// File: tb/tb_list_writer.sv
// Randomized bench for list_writer against a
// queue-based model of pending writes and list.
module tb_list_writer;

  localparam int MAXN = 4;
  localparam int BASE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clear = 1'b0;
  logic        in_ready, we, list_full, busy;
  logic [7:0]  waddr, head_addr;
  logic [31:0] wdata;
  logic [2:0]  node_count;

  list_writer #(
    .DATA_W    (32),
    .ADDR_W    (8),
    .BASE_ADDR (BASE),
    .MAX_NODES (MAXN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear      (clear),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .head_addr  (head_addr),
    .node_count (node_count),
    .list_full  (list_full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic        last;
  } wr_t;

  wr_t         q[$];
  logic [31:0] vals[$];
  int          m_cnt = 0;
  logic [7:0]  m_head = '0;
  bit          m_pend = 0;
  bit [31:0]   mem[256];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    vals.delete();
    m_cnt  = 0;
    m_head = '0;
    m_pend = 0;
  endtask

  task automatic step(input bit v,
                      input logic [31:0] d,
                      input bit c);
    bit          idle, rdy;
    wr_t         e;
    logic        cw;
    logic [7:0]  ca, nw, tl;
    logic [31:0] cd;
    in_valid = v;
    in_data  = d;
    clear    = c;
    #1;
    idle = (q.size() == 0);
    rdy  = idle && (m_cnt < MAXN) && !m_pend && !c;
    e    = idle ? '0 : q[0];
    chk("in_ready", in_ready, rdy);
    chk("we", we, !idle);
    chk("waddr", waddr, e.a);
    chk("wdata", wdata, e.d);
    chk("busy", busy, !idle);
    chk("head", head_addr, m_head);
    chk("count", node_count, m_cnt);
    chk("full", list_full, m_cnt == MAXN);
    cw = we; ca = waddr; cd = wdata;
    @(posedge clk);
    if (cw) mem[ca] = cd;
    if (!idle) begin
      e = q.pop_front();
      if (e.last) begin
        if (m_cnt == 0) m_head = 8'(BASE);
        m_cnt++;
      end
      if (c) m_pend = 1;
    end else if (c || m_pend) begin
      model_reset();
    end else if (v && m_cnt < MAXN) begin
      nw = 8'(BASE + 2 * m_cnt);
      tl = 8'(BASE + 2 * (m_cnt - 1));
      q.push_back({nw, d, 1'b0});
      q.push_back({8'(nw + 1), 32'd0, 1'(m_cnt == 0)});
      if (m_cnt > 0)
        q.push_back({8'(tl + 1), {24'd0, nw}, 1'b1});
      vals.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic walk(input string tag);
    logic [7:0]  p;
    logic [31:0] s, es;
    int          n;
    p = head_addr; s = 0; es = 0; n = 0;
    while (p != 0 && n <= MAXN) begin
      s += mem[p];
      p = mem[8'(p + 1)][7:0];
      n++;
    end
    foreach (vals[i]) es += vals[i];
    chk({tag, "_len"}, n, vals.size());
    chk({tag, "_sum"}, s, es);
    chk({tag, "_end"}, {24'd0, p}, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) step(0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_we", we, 0);
    chk("t1_head", head_addr, 0);
    chk("t1_cnt", node_count, 0);
    rst = 1'b1;
    step(0, 0, 0);

    step(1, 5, 0);
    drain();
    walk("t2");
    step(1, 7, 0);
    drain();
    step(1, 9, 0);
    drain();
    walk("t3");
    chk("t3_sum21", vals.size() == 3 ? vals[0] + vals[1] + vals[2] : 0, 21);

    step(0, 0, 1);
    for (int k = 0; k < 24; k++) step(1, 32'(100 + k), 0);
    drain();
    chk("t4_full", list_full, 1);
    walk("t4");

    step(0, 0, 1);
    step(1, 3, 0);
    drain();
    step(1, 4, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    drain();
    chk("t5_cnt", node_count, 0);
    step(1, 55, 0);
    drain();
    walk("t5");

    step(1, 33, 0);
    in_valid = 1'b0;
    #1;
    chk("t6_we_pre", we, 1);
    rst = 1'b0;
    #1;
    chk("t6_we", we, 0);
    chk("t6_head", head_addr, 0);
    chk("t6_cnt", node_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom,
           ($urandom % 25) == 0);
      if (q.size() == 0 && !m_pend && (i % 6) == 0)
        walk("rnd");
    end
    drain();
    walk("end");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
